// File: rtl/mips_pc_sequencer_if.sv
// Redirect/fetch handshake between pipeline resolution logic and the PC sequencer.
// master drives requests and fetch status; slave returns the PC action and status.
interface mips_pc_sequencer_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 16,
  parameter int JUMP_W   = 26,
  parameter int COUNT_W  = 16
);
  logic                stall;
  logic                fetchReady;
  logic                reqBranch;
  logic                reqJump;
  logic                reqJumpR;
  logic [OFFSET_W-1:0] inOffset;
  logic [JUMP_W-1:0]   inJump;
  logic [ADDR_W-1:0]   inJumpr;
  logic [2:0]          action;
  logic [OFFSET_W-1:0] offset;
  logic [JUMP_W-1:0]   jump;
  logic [ADDR_W-1:0]   jumpr;
  logic                fetchValid;
  logic                flush;
  logic                busy;
  logic                overrun;
  logic [COUNT_W-1:0]  redirects;

  modport master (
    output stall, fetchReady, reqBranch, reqJump, reqJumpR, inOffset, inJump, inJumpr,
    input  action, offset, jump, jumpr, fetchValid, flush, busy, overrun, redirects
  );

  modport slave (
    input  stall, fetchReady, reqBranch, reqJump, reqJumpR, inOffset, inJump, inJumpr,
    output action, offset, jump, jumpr, fetchValid, flush, busy, overrun, redirects
  );
endinterface

// File: rtl/mips_pc_sequencer.sv
// Drives the PC unit action/operands; direct redirects issue combinationally (0 cycles),
// redirects blocked by stall or !fetchReady are held pending and issue on the first go cycle.
module mips_pc_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 16,
  parameter int JUMP_W   = 26,
  parameter int COUNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_pc_sequencer_if.slave   bus
);

  localparam logic [2:0] ACT_NONE   = 3'd0;
  localparam logic [2:0] ACT_INC    = 3'd1;
  localparam logic [2:0] ACT_BRANCH = 3'd2;
  localparam logic [2:0] ACT_JUMP   = 3'd3;
  localparam logic [2:0] ACT_JUMPR  = 3'd4;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]          state_q;
  logic [2:0]          pend_kind_q;
  logic [OFFSET_W-1:0] pend_offset_q;
  logic [JUMP_W-1:0]   pend_jump_q;
  logic [ADDR_W-1:0]   pend_jumpr_q;
  logic                overrun_q;
  logic [COUNT_W-1:0]  redirects_q;

  logic                go;
  logic                any_req;
  logic [2:0]          win_kind;
  logic [OFFSET_W-1:0] win_offset;
  logic [JUMP_W-1:0]   win_jump;
  logic [ADDR_W-1:0]   win_jumpr;

  logic [2:0]          action_c;
  logic [OFFSET_W-1:0] offset_c;
  logic [JUMP_W-1:0]   jump_c;
  logic [ADDR_W-1:0]   jumpr_c;
  logic                issue;
  logic                busy_c;
  logic [1:0]          state_d;

  assign go      = bus.fetchReady & ~bus.stall;
  assign any_req = bus.reqJumpR | bus.reqJump | bus.reqBranch;

  // Only the winning operand is carried; the losers are zeroed here so the
  // pending registers and outputs never hold stale operands.
  always_comb begin
    win_kind   = ACT_BRANCH;
    win_offset = '0;
    win_jump   = '0;
    win_jumpr  = '0;
    if (bus.reqJumpR) begin
      win_kind  = ACT_JUMPR;
      win_jumpr = bus.inJumpr;
    end else if (bus.reqJump) begin
      win_kind = ACT_JUMP;
      win_jump = bus.inJump;
    end else begin
      win_offset = bus.inOffset;
    end
  end

  always_comb begin
    action_c = ACT_NONE;
    offset_c = '0;
    jump_c   = '0;
    jumpr_c  = '0;
    issue    = 1'b0;
    busy_c   = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (any_req) begin
          if (go) begin
            action_c = win_kind;
            offset_c = win_offset;
            jump_c   = win_jump;
            jumpr_c  = win_jumpr;
            issue    = 1'b1;
          end else begin
            state_d = ST_PEND;
          end
        end else if (go) begin
          action_c = ACT_INC;
        end
      end
      ST_PEND: begin
        busy_c = 1'b1;
        if (go) begin
          action_c = pend_kind_q;
          offset_c = pend_offset_q;
          jump_c   = pend_jump_q;
          jumpr_c  = pend_jumpr_q;
          issue    = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pend_kind_q   <= ACT_NONE;
      pend_offset_q <= '0;
      pend_jump_q   <= '0;
      pend_jumpr_q  <= '0;
      overrun_q     <= 1'b0;
      redirects_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN && any_req && !go) begin
        pend_kind_q   <= win_kind;
        pend_offset_q <= win_offset;
        pend_jump_q   <= win_jump;
        pend_jumpr_q  <= win_jumpr;
      end else if (state_q == ST_PEND && go) begin
        pend_kind_q   <= ACT_NONE;
        pend_offset_q <= '0;
        pend_jump_q   <= '0;
        pend_jumpr_q  <= '0;
      end
      // Requests arriving while a redirect is pending are dropped and flagged.
      if (state_q == ST_PEND && any_req) begin
        overrun_q <= 1'b1;
      end
      if (issue && (redirects_q != {COUNT_W{1'b1}})) begin
        redirects_q <= redirects_q + COUNT_W'(1);
      end
    end
  end

  assign bus.action     = action_c;
  assign bus.offset     = offset_c;
  assign bus.jump       = jump_c;
  assign bus.jumpr      = jumpr_c;
  assign bus.fetchValid = (action_c != ACT_NONE);
  assign bus.flush      = issue;
  assign bus.busy       = busy_c;
  assign bus.overrun    = overrun_q;
  assign bus.redirects  = redirects_q;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for mips_pc_sequencer; a second instance with COUNT_W=2 shares the stimulus.
module tb_mips_pc_sequencer;
  localparam logic [2:0] A_NONE = 3'd0;
  localparam logic [2:0] A_INC  = 3'd1;
  localparam logic [2:0] A_BR   = 3'd2;
  localparam logic [2:0] A_J    = 3'd3;
  localparam logic [2:0] A_JR   = 3'd4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mips_pc_sequencer_if #(.COUNT_W(16)) bus ();
  mips_pc_sequencer_if #(.COUNT_W(2))  bus2 ();

  assign bus2.stall      = bus.stall;
  assign bus2.fetchReady = bus.fetchReady;
  assign bus2.reqBranch  = bus.reqBranch;
  assign bus2.reqJump    = bus.reqJump;
  assign bus2.reqJumpR   = bus.reqJumpR;
  assign bus2.inOffset   = bus.inOffset;
  assign bus2.inJump     = bus.inJump;
  assign bus2.inJumpr    = bus.inJumpr;

  mips_pc_sequencer #(.COUNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mips_pc_sequencer #(.COUNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.reqBranch = 1'b0;
    bus.reqJump   = 1'b0;
    bus.reqJumpR  = 1'b0;
    bus.inOffset  = '0;
    bus.inJump    = '0;
    bus.inJumpr   = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.stall      = 1'b0;
    bus.fetchReady = 1'b1;
    idle();

    // Reset held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_action", bus.action, A_NONE);
    chk("rst_fetchValid", bus.fetchValid, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_redirects", bus.redirects, 0);

    // Release: BOOT cycle then five Inc cycles
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_action", bus.action, A_NONE);
    chk("boot_fetchValid", bus.fetchValid, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("inc%0d_action", i), bus.action, A_INC);
      chk($sformatf("inc%0d_fetchValid", i), bus.fetchValid, 1);
    end
    chk("inc_redirects", bus.redirects, 0);

    // Direct branch
    @(negedge clk);
    bus.reqBranch = 1'b1;
    bus.inOffset  = 16'hFFFE;
    #1;
    chk("br_action", bus.action, A_BR);
    chk("br_offset", bus.offset, 16'hFFFE);
    chk("br_flush", bus.flush, 1);
    chk("br_jump", bus.jump, 0);
    chk("br_jumpr", bus.jumpr, 0);
    @(negedge clk);
    idle();
    #1;
    chk("br_redirects", bus.redirects, 1);
    chk("br_after_flush", bus.flush, 0);
    chk("br_after_action", bus.action, A_INC);

    // Jump held by stall: request cycle, three PEND stall cycles, then issue
    @(negedge clk);
    bus.reqJump = 1'b1;
    bus.inJump  = 26'h0000100;
    bus.stall   = 1'b1;
    #1;
    chk("jp_req_action", bus.action, A_NONE);
    chk("jp_req_flush", bus.flush, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      bus.inJump = 26'h3FFFFFF;
      #1;
      chk($sformatf("jp_pend%0d_busy", i), bus.busy, 1);
      chk($sformatf("jp_pend%0d_action", i), bus.action, A_NONE);
      chk($sformatf("jp_pend%0d_flush", i), bus.flush, 0);
    end
    @(negedge clk);
    bus.stall = 1'b0;
    #1;
    chk("jp_issue_action", bus.action, A_J);
    chk("jp_issue_jump", bus.jump, 26'h0000100);
    chk("jp_issue_flush", bus.flush, 1);
    chk("jp_issue_fetchValid", bus.fetchValid, 1);
    @(negedge clk);
    idle();
    #1;
    chk("jp_after_action", bus.action, A_INC);
    chk("jp_after_busy", bus.busy, 0);
    chk("jp_after_flush", bus.flush, 0);
    chk("jp_redirects", bus.redirects, 2);
    chk("jp_overrun", bus.overrun, 0);

    // Priority: all three requests at once
    @(negedge clk);
    bus.reqJumpR = 1'b1;
    bus.reqJump  = 1'b1;
    bus.reqBranch = 1'b1;
    bus.inJumpr  = 32'h00400040;
    bus.inJump   = 26'h0000123;
    bus.inOffset = 16'h0055;
    #1;
    chk("pri_action", bus.action, A_JR);
    chk("pri_jumpr", bus.jumpr, 32'h00400040);
    chk("pri_jump", bus.jump, 0);
    chk("pri_offset", bus.offset, 0);
    chk("pri_flush", bus.flush, 1);
    @(negedge clk);
    idle();
    #1;
    chk("pri_redirects", bus.redirects, 3);
    chk("pri_after_flush", bus.flush, 0);

    // Overrun: request during PEND is dropped, original issues unchanged
    @(negedge clk);
    bus.reqBranch = 1'b1;
    bus.inOffset  = 16'h0010;
    bus.stall     = 1'b1;
    #1;
    chk("ov_req_action", bus.action, A_NONE);
    @(negedge clk);
    bus.reqBranch = 1'b1;
    bus.inOffset  = 16'h0020;
    #1;
    chk("ov_pend_busy", bus.busy, 1);
    chk("ov_pend_overrun", bus.overrun, 0);
    @(negedge clk);
    idle();
    bus.stall = 1'b0;
    #1;
    chk("ov_set", bus.overrun, 1);
    chk("ov_issue_action", bus.action, A_BR);
    chk("ov_issue_offset", bus.offset, 16'h0010);
    chk("ov_issue_flush", bus.flush, 1);
    @(negedge clk);
    #1;
    chk("ov_sticky", bus.overrun, 1);
    chk("ov_after_action", bus.action, A_INC);
    chk("ov_redirects", bus.redirects, 4);

    // Reset mid-PEND discards the pending jump
    @(negedge clk);
    bus.reqJump = 1'b1;
    bus.inJump  = 26'h0000ABC;
    bus.stall   = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("rp_busy", bus.busy, 1);
    @(negedge clk);
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    #1;
    chk("rp_action", bus.action, A_NONE);
    chk("rp_flush", bus.flush, 0);
    chk("rp_busy_clr", bus.busy, 0);
    chk("rp_overrun_clr", bus.overrun, 0);
    chk("rp_redirects_clr", bus.redirects, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rp_boot_action", bus.action, A_NONE);
    chk("rp_boot_flush", bus.flush, 0);
    @(negedge clk);
    #1;
    chk("rp_run_action", bus.action, A_INC);
    chk("rp_run_flush", bus.flush, 0);

    // Saturating counter on the COUNT_W=2 instance: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      #1;
      if (i > 0) chk($sformatf("sat%0d_redirects", i), bus2.redirects, (i > 3) ? 3 : i);
      bus.reqBranch = 1'b1;
      bus.inOffset  = 16'h0004;
      #1;
      chk($sformatf("sat%0d_flush", i), bus2.flush, 1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("sat_final", bus2.redirects, 3);
    chk("wide_redirects", bus.redirects, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
